imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the RISC-V decode stage.
- Decodes the instruction format from the opcode and produces the sign-extended immediate at XLEN width (32 or 64).
- Zero-extends shift amounts and flags illegal or unsupported opcodes.
- Sits between fetch and decode behind a valid/ready handshake, with one output register and a one-entry skid buffer, so the stage sustains full throughput under backpressure.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64. RV64-only opcodes are illegal when XLEN=32.
- TAG_W, 32, width of the sideband tag (e.g. PC) carried alongside each instruction.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  input instruction valid
- in_ready  out  1  stage can accept an instruction
- in_inst  in  32  instruction word
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_imm  out  XLEN  immediate
- out_fmt  out  3  format code (see Decomposition)
- out_illegal  out  1  illegal or unsupported encoding
- out_tag  out  TAG_W  tag that travelled with the instruction

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: out_valid=0, out_imm=0, out_fmt=FMT_R, out_illegal=0, out_tag=0, skid buffer empty.
  - in_ready is 1 after reset and is the registered inverse of skid-full.
- Latency: an instruction accepted on edge N is presented at out_* after edge N, i.e. one cycle.
- Handshake rules:
  - A transfer occurs when valid && ready.
  - out_* stay stable while out_valid && !out_ready.
  - Throughput is 1 per cycle when out_ready=1.
- Skid buffer:
  - If the output register holds an unaccepted result and a new instruction is accepted, the new result goes to the skid entry and in_ready falls next cycle.
  - When the output is consumed, the skid entry moves to the output register and in_ready returns.
  - Order is always preserved; nothing is dropped or duplicated.
- Flush:
  - Clears out_valid and the skid entry on the next edge.
  - Has priority over any same-cycle acceptance; in_ready is forced to 0 while flush=1.
- Decode, keyed on in_inst[6:0]; all immediates are sign-extended from inst[31] to XLEN:
  - I format (FMT_I), imm = inst[31:20]: LOAD 0000011, OP-IMM 0010011, JALR 1100111, FENCE 0001111, SYSTEM 1110011.
  - Shift form (FMT_SH): OP-IMM with funct3 001 or 101, imm = zero-extended shamt.
    - XLEN=32: shamt = inst[24:20]; inst[25]=1 is illegal.
    - XLEN=64: shamt = inst[25:20].
  - S format (FMT_S), opcode 0100011: {inst[31:25], inst[11:7]}.
  - B format (FMT_B), opcode 1100011: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U format (FMT_U), LUI 0110111 / AUIPC 0010111: {inst[31:12], 12'b0}.
  - J format (FMT_J), opcode 1101111: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R format (FMT_R), OP 0110011: imm = 0.
  - XLEN=64 only:
    - OP-IMM-32 0011011 decodes as I, or SH with a 5-bit shamt; inst[25]=1 is illegal.
    - OP-32 0111011 decodes as R.
  - Illegal (FMT_ILL, out_illegal=1, imm=0): in_inst[1:0] != 2'b11, any other opcode, or an RV64-only opcode with XLEN=32.
- Reset mid-operation: asserting rst_n low at any time discards both the output and skid entries asynchronously.

Decomposition:
- Package imm_gen_pkg holds:
  - fmt codes: FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_SH=6, FMT_ILL=7;
  - opcode constants;
  - a function for XLEN sign-extension.
- One combinational sub-module, imm_decode, maps (inst) -> (imm, fmt, illegal) for a given XLEN.
- The top level holds the output register, the skid buffer and the handshake logic.

Test Plan:
- XLEN=32, addi inst 0xFFF00093 -> one cycle later out_imm=0xFFFFFFFF, fmt=FMT_I, illegal=0.
- XLEN=32, sw 0xFE112E23 then beq 0xFE000CE3 back-to-back with out_ready=1 -> out_imm 0xFFFFFFFC (FMT_S), then 0xFFFFFFF8 (FMT_B) on consecutive cycles, with tags matching.
- XLEN=64:
  - lui 0x800000B7 -> out_imm=0xFFFFFFFF80000000, FMT_U;
  - srai 0x43F0D093 -> out_imm=0x3F, FMT_SH.
  - With XLEN=32, the same srai -> illegal=1, imm=0.
- Backpressure: out_ready=0 while driving 3 valid instructions.
  - in_ready falls after 2 acceptances.
  - Raising out_ready then drains all 3 in order with no duplicates.
- Flush asserted while the output and skid entries are both full, with in_valid=1 -> out_valid=0 next cycle, in_ready=0 during flush, the input is not accepted.
- Corner cases:
  - inst 0x00000000 -> FMT_ILL, illegal=1.
  - rst_n pulsed low mid-stream -> out_valid=0 immediately (asynchronous), in_ready=1 after release.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// Shared definitions for the immediate generator pipeline.
//   fmt_e    : format code reported on out_fmt
//   OPC_*    : RISC-V major opcodes (full 7-bit field, including the 2'b11 quadrant bits)
//   sext64() : sign-extends a 32-bit immediate to 64 bits; callers truncate to XLEN
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_SH  = 3'd6,
        FMT_ILL = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    function automatic logic [63:0] sext64(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder.
//   inst    : 32-bit instruction word
//   imm     : XLEN-bit immediate (sign-extended, or zero-extended shamt)
//   fmt     : format code (imm_gen_pkg::fmt_e encoding)
//   illegal : encoding is illegal or unsupported at this XLEN
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    logic [31:0] raw;     // 32-bit immediate before widening to XLEN
    fmt_e        fmt_d;
    logic        is_shift;

    assign is_shift = (inst[14:12] == 3'b001) || (inst[14:12] == 3'b101);

    always_comb begin
        raw   = '0;
        fmt_d = FMT_ILL;
        // Matching the full 7-bit opcode also rejects inst[1:0] != 2'b11.
        case (inst[6:0])
            OPC_LOAD, OPC_JALR, OPC_FENCE, OPC_SYSTEM: begin
                fmt_d = FMT_I;
                raw   = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_OP_IMM: begin
                if (!is_shift) begin
                    fmt_d = FMT_I;
                    raw   = {{20{inst[31]}}, inst[31:20]};
                end else if (XLEN == 64) begin
                    fmt_d = FMT_SH;
                    raw   = {26'd0, inst[25:20]};
                end else if (!inst[25]) begin
                    fmt_d = FMT_SH;
                    raw   = {27'd0, inst[24:20]};
                end
            end
            OPC_OP_IMM_32: begin
                if (XLEN == 64) begin
                    if (!is_shift) begin
                        fmt_d = FMT_I;
                        raw   = {{20{inst[31]}}, inst[31:20]};
                    end else if (!inst[25]) begin
                        fmt_d = FMT_SH;
                        raw   = {27'd0, inst[24:20]};
                    end
                end
            end
            OPC_STORE: begin
                fmt_d = FMT_S;
                raw   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OPC_BRANCH: begin
                fmt_d = FMT_B;
                raw   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt_d = FMT_U;
                raw   = {inst[31:12], 12'd0};
            end
            OPC_JAL: begin
                fmt_d = FMT_J;
                raw   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OPC_OP: begin
                fmt_d = FMT_R;
            end
            OPC_OP_32: begin
                if (XLEN == 64) begin
                    fmt_d = FMT_R;
                end
            end
            default: begin
                fmt_d = FMT_ILL;
            end
        endcase
    end

    // Shift amounts carry a clear bit 31, so sign-extension leaves them zero-extended.
    assign imm     = XLEN'(sext64(raw));
    assign fmt     = fmt_d;
    assign illegal = (fmt_d == FMT_ILL);

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator stage (fetch -> decode) with valid/ready handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous flush of output and skid entries
//   in_valid/in_ready   : input handshake; in_inst, in_tag carried in
//   out_valid/out_ready : output handshake
//   out_imm/out_fmt/out_illegal/out_tag : registered decode result and sideband tag
// One output register plus a one-entry skid buffer keeps full throughput under
// backpressure; in_ready is the registered inverse of skid-full, gated by flush.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  dec_imm;
    logic [2:0]       dec_fmt;
    logic             dec_ill;

    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [2:0]       skid_fmt;
    logic             skid_ill;
    logic [TAG_W-1:0] skid_tag;

    logic             accept;
    logic             out_free;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .inst    (in_inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_ill)
    );

    assign in_ready = !skid_valid && !flush;
    assign accept   = in_valid && in_ready;
    // Output register can take new data when empty or being consumed this cycle.
    assign out_free = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_imm     <= '0;
            out_fmt     <= FMT_R;
            out_illegal <= 1'b0;
            out_tag     <= '0;
            skid_valid  <= 1'b0;
            skid_imm    <= '0;
            skid_fmt    <= FMT_R;
            skid_ill    <= 1'b0;
            skid_tag    <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            // in_ready is low whenever the skid is full, so draining the skid
            // and accepting a new instruction never coincide.
            if (skid_valid) begin
                out_valid   <= 1'b1;
                out_imm     <= skid_imm;
                out_fmt     <= skid_fmt;
                out_illegal <= skid_ill;
                out_tag     <= skid_tag;
                skid_valid  <= 1'b0;
            end else if (accept) begin
                out_valid   <= 1'b1;
                out_imm     <= dec_imm;
                out_fmt     <= dec_fmt;
                out_illegal <= dec_ill;
                out_tag     <= in_tag;
            end else begin
                out_valid   <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_imm   <= dec_imm;
            skid_fmt   <= dec_fmt;
            skid_ill   <= dec_ill;
            skid_tag   <= in_tag;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        rdy32, vld32, ill32;
    logic [31:0] imm32, tag32;
    logic [2:0]  fmt32;
    logic        rdy64, vld64, ill64;
    logic [63:0] imm64;
    logic [31:0] tag64;
    logic [2:0]  fmt64;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
        .out_illegal(ill32), .out_tag(tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
        .out_illegal(ill64), .out_tag(tag64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] tag);
        in_valid = v;
        in_inst  = inst;
        in_tag   = tag;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        #2;
        chk("rst_vld", {63'd0, vld32}, 64'd0);
        chk("rst_rdy", {63'd0, rdy32}, 64'd1);
        chk("rst_imm", {32'd0, imm32}, 64'd0);
        chk("rst_fmt", {61'd0, fmt32}, 64'd0);
        chk("rst_ill", {63'd0, ill32}, 64'd0);
        chk("rst_tag", {32'd0, tag32}, 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // addi x1,x0,-1
        drive(1'b1, 32'hFFF00093, 32'h100); tick();
        chk("addi_vld", {63'd0, vld32}, 64'd1);
        chk("addi_imm32", {32'd0, imm32}, 64'hFFFFFFFF);
        chk("addi_fmt", {61'd0, fmt32}, 64'd1);
        chk("addi_ill", {63'd0, ill32}, 64'd0);
        chk("addi_tag", {32'd0, tag32}, 64'h100);
        chk("addi_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);

        // sw then beq back-to-back
        drive(1'b1, 32'hFE112E23, 32'h104); tick();
        chk("sw_imm", {32'd0, imm32}, 64'hFFFFFFFC);
        chk("sw_fmt", {61'd0, fmt32}, 64'd2);
        chk("sw_tag", {32'd0, tag32}, 64'h104);
        drive(1'b1, 32'hFE000CE3, 32'h108); tick();
        chk("beq_vld", {63'd0, vld32}, 64'd1);
        chk("beq_imm", {32'd0, imm32}, 64'hFFFFFFF8);
        chk("beq_fmt", {61'd0, fmt32}, 64'd3);
        chk("beq_tag", {32'd0, tag32}, 64'h108);

        // lui
        drive(1'b1, 32'h800000B7, 32'h10C); tick();
        chk("lui_imm64", imm64, 64'hFFFFFFFF80000000);
        chk("lui_fmt64", {61'd0, fmt64}, 64'd4);
        chk("lui_imm32", {32'd0, imm32}, 64'h80000000);

        // srai with 6-bit shamt: legal on RV64 only
        drive(1'b1, 32'h43F0D093, 32'h110); tick();
        chk("srai_imm64", imm64, 64'h3F);
        chk("srai_fmt64", {61'd0, fmt64}, 64'd6);
        chk("srai_ill64", {63'd0, ill64}, 64'd0);
        chk("srai_ill32", {63'd0, ill32}, 64'd1);
        chk("srai_imm32", {32'd0, imm32}, 64'd0);
        chk("srai_fmt32", {61'd0, fmt32}, 64'd7);

        // srli x1,x1,3 on RV32: 5-bit shamt
        drive(1'b1, 32'h0030D093, 32'h112); tick();
        chk("srli_imm32", {32'd0, imm32}, 64'h3);
        chk("srli_fmt32", {61'd0, fmt32}, 64'd6);

        // addiw: RV64-only
        drive(1'b1, 32'hFFF0009B, 32'h114); tick();
        chk("addiw_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
        chk("addiw_fmt64", {61'd0, fmt64}, 64'd1);
        chk("addiw_ill32", {63'd0, ill32}, 64'd1);

        // jal x1,-4
        drive(1'b1, 32'hFFDFF0EF, 32'h118); tick();
        chk("jal_imm", {32'd0, imm32}, 64'hFFFFFFFC);
        chk("jal_fmt", {61'd0, fmt32}, 64'd5);

        // add x3,x1,x2
        drive(1'b1, 32'h002081B3, 32'h11C); tick();
        chk("add_imm", {32'd0, imm32}, 64'd0);
        chk("add_fmt", {61'd0, fmt32}, 64'd0);
        chk("add_ill", {63'd0, ill32}, 64'd0);

        // all-zero word
        drive(1'b1, 32'h00000000, 32'h120); tick();
        chk("zero_fmt", {61'd0, fmt32}, 64'd7);
        chk("zero_ill", {63'd0, ill32}, 64'd1);
        chk("zero_ill64", {63'd0, ill64}, 64'd1);

        drive(1'b0, 32'h0, 32'h0); tick();
        chk("idle_vld", {63'd0, vld32}, 64'd0);

        // Backpressure: three instructions with out_ready low
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h200); tick();
        chk("bp_vld_a", {63'd0, vld32}, 64'd1);
        chk("bp_rdy_a", {63'd0, rdy32}, 64'd1);
        drive(1'b1, 32'h00200093, 32'h201); tick();
        chk("bp_rdy_b", {63'd0, rdy32}, 64'd0);
        chk("bp_hold_b", {32'd0, tag32}, 64'h200);
        drive(1'b1, 32'h00300093, 32'h202); tick();
        chk("bp_rdy_c", {63'd0, rdy32}, 64'd0);
        chk("bp_hold_c", {32'd0, tag32}, 64'h200);
        chk("bp_hold_imm", {32'd0, imm32}, 64'd1);
        out_ready = 1'b1; tick();
        chk("dr_tag_b", {32'd0, tag32}, 64'h201);
        chk("dr_imm_b", {32'd0, imm32}, 64'd2);
        chk("dr_rdy", {63'd0, rdy32}, 64'd1);
        tick();
        chk("dr_tag_c", {32'd0, tag32}, 64'h202);
        chk("dr_imm_c", {32'd0, imm32}, 64'd3);
        chk("dr_vld_c", {63'd0, vld32}, 64'd1);
        drive(1'b0, 32'h0, 32'h0); tick();
        chk("dr_empty", {63'd0, vld32}, 64'd0);

        // Flush with output and skid both full
        out_ready = 1'b0;
        drive(1'b1, 32'h00400093, 32'h300); tick();
        drive(1'b1, 32'h00500093, 32'h301); tick();
        chk("fl_full", {63'd0, rdy32}, 64'd0);
        drive(1'b1, 32'h00600093, 32'h302);
        flush = 1'b1; #1;
        chk("fl_rdy", {63'd0, rdy32}, 64'd0);
        tick();
        chk("fl_vld", {63'd0, vld32}, 64'd0);
        flush = 1'b0; #1;
        chk("fl_rdy_after", {63'd0, rdy32}, 64'd1);
        // Flush with an empty stage still blocks acceptance
        flush = 1'b1; #1;
        chk("fl2_rdy", {63'd0, rdy32}, 64'd0);
        tick();
        chk("fl2_vld", {63'd0, vld32}, 64'd0);
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0); tick();
        chk("fl2_none", {63'd0, vld32}, 64'd0);

        // Asynchronous reset mid-stream with both entries full
        out_ready = 1'b0;
        drive(1'b1, 32'h00700093, 32'h400); tick();
        drive(1'b1, 32'h00800093, 32'h401); tick();
        chk("ar_pre_vld", {63'd0, vld32}, 64'd1);
        #2 rst_n = 1'b0; #1;
        chk("ar_vld", {63'd0, vld32}, 64'd0);
        chk("ar_rdy", {63'd0, rdy32}, 64'd1);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_rdy_rel", {63'd0, rdy32}, 64'd1);
        chk("ar_vld_rel", {63'd0, vld32}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
